// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write register file with write-through forwarding,
// a per-entry pending scoreboard and a post-reset zeroing sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  input  logic              w0_en_i,
  input  logic [ADDR_W-1:0] w0_addr_i,
  input  logic [DATA_W-1:0] w0_data_i,
  input  logic              w1_en_i,
  input  logic [ADDR_W-1:0] w1_addr_i,
  input  logic [DATA_W-1:0] w1_data_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend, pend_nx;
  logic run, w0_ok, w1_ok, set_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && a == '0;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= INIT;
    else       state <= state_nx;

  always_comb state_nx = (state == INIT && cnt == ADDR_W'(DEPTH - 1)) ? RUN : state;

  always_comb begin
    run     = state == RUN;
    ready_o = run;
  end

  // Writes and sets are only honoured in RUN and never reach a hardwired zero entry
  always_comb begin
    w0_ok  = run && w0_en_i && !is_zero(w0_addr_i);
    w1_ok  = run && w1_en_i && !is_zero(w1_addr_i);
    set_ok = run && set_en_i && !is_zero(set_addr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)              cnt <= '0;
    else if (state == INIT) cnt <= cnt + 1'b1;

  // Storage has no reset; the sweep clears it and reads are masked until it ends
  always_ff @(posedge clk_i)
    if (state == INIT) mem[cnt] <= '0;
    else begin
      if (w0_ok) mem[w0_addr_i] <= w0_data_i;
      if (w1_ok) mem[w1_addr_i] <= w1_data_i;
    end

  always_comb begin
    pend_nx = pend;
    for (int i = 0; i < DEPTH; i++)
      pend_nx[i] = (set_ok && set_addr_i == ADDR_W'(i)) ||
                   (pend[i] && !(w0_ok && w0_addr_i == ADDR_W'(i)) && !(w1_ok && w1_addr_i == ADDR_W'(i)));
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pend <= '0;
    else       pend <= pend_nx;

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    if (!run || is_zero(a))       return '0;
    if (w1_ok && w1_addr_i == a)  return w1_data_i;
    if (w0_ok && w0_addr_i == a)  return w0_data_i;
    return mem[a];
  endfunction

  // An in-flight write hides the stale pending bit unless a new producer claims the entry
  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    logic hit;
    hit = (w0_ok && w0_addr_i == a) || (w1_ok && w1_addr_i == a);
    if (!run || is_zero(a)) return 1'b0;
    return hit ? (set_ok && set_addr_i == a) : pend[a];
  endfunction

  always_comb begin
    rs_data_o = rd_data(rs_addr_i);
    rt_data_o = rd_data(rt_addr_i);
    rs_busy_o = rd_busy(rs_addr_i);
    rt_busy_o = rd_busy(rt_addr_i);
  end
endmodule
